// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit: datapath width, the
// fetch step size, the default reset fetch address and the FSM state type.
package instr_fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // FETCH: normal issue/accept; FLUSH: dropping responses to requests that
  // were in flight when a redirect happened.
  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo
// Small synchronous FIFO holding fetched {pc, word} pairs.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push, i_wdata write an entry (accepted when not full, or when full
//                   together with a pop)
//   i_pop           drop the head entry (ignored when empty)
//   i_flush         empty the FIFO; wins over push and pop
//   o_rdata         head entry, combinational
//   o_full/o_empty  occupancy flags
//   o_count         number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Issues sequential instruction fetches, buffers returned words in order and
// presents them to the decoder; a redirect restarts fetch at a new address
// and throws away every response still in flight.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt     request channel; a request completes on
//                                   req & gnt, addr held until then
//   imem_rvalid/imem_rdata          in-order responses
//   redirect/redirect_pc            taken branch/jump target
//   instr_valid/instr/instr_pc      head of the instruction buffer
//   instr_ready                     decoder consumes head on valid & ready
//   misalign_err                    sticky misaligned-redirect flag, only when
//                                   FETCH_MISALIGN_CHECK_EN is defined
// Handshake: a transfer happens on a rising edge where the sender's
// req/valid and the receiver's gnt/ready are both 1; the sender holds its
// payload until then.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [CW-1:0]    r_outstanding;   // every request granted but not answered
  logic [CW-1:0]    r_discard;       // of those, how many must be dropped
  logic [CW-1:0]    w_out_next;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_inflight;
  logic             w_grant;
  logic             w_rsp;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [XLEN-1:0]  w_target;
  logic [2*XLEN-1:0] w_head;

  // Credit: never have more words in flight or buffered than buffer slots,
  // so every response always has a place to land.
  assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_count};
  assign imem_req    = rst_n && (r_state == FETCH) && (w_inflight < DEPTH_C);
  assign imem_addr   = r_fetch_pc;
  assign w_grant     = imem_req && imem_gnt;
  assign w_rsp       = imem_rvalid && (r_outstanding != '0);

  assign instr_valid = !w_empty && (r_state == FETCH);
  assign instr_pc    = w_head[2*XLEN-1:XLEN];
  assign instr       = w_head[XLEN-1:0];

  // Redirect wins over everything else in the same cycle.
  assign w_push   = w_rsp && (r_state == FETCH) && !redirect && (!w_full || w_pop);
  assign w_pop    = instr_valid && instr_ready && !redirect;
  assign w_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifndef FETCH_MISALIGN_CHECK_EN
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];
`endif

  always_comb begin
    w_out_next = r_outstanding;
    if (w_grant && !w_rsp)      w_out_next = r_outstanding + CW'(1);
    else if (!w_grant && w_rsp) w_out_next = r_outstanding - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (redirect) begin
      // Includes a request granted in the redirect cycle itself.
      w_state_next = (w_out_next != '0) ? FLUSH : FETCH;
    end else if ((r_state == FLUSH) && w_rsp && (r_discard == CW'(1))) begin
      w_state_next = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect) begin
        r_fetch_pc <= w_target;
        r_discard  <= w_out_next;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
        if ((r_state == FLUSH) && w_rsp) r_discard <= r_discard - CW'(1);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_misalign <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00)) r_misalign <= 1'b1;
  end
  assign misalign_err = r_misalign;
`endif

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({r_pc_for_rsp(r_fetch_pc, r_outstanding), imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // The response being written belongs to the oldest outstanding request:
  // fetch_pc has already moved past every outstanding one.
  function automatic logic [XLEN-1:0] r_pc_for_rsp(input logic [XLEN-1:0] pc,
                                                   input logic [CW-1:0]   outst);
    return pc - (XLEN'(outst) * XLEN'(INSTR_BYTES));
  endfunction

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  // ---------------- memory model / monitor ----------------
  int          lat   = 1;
  logic        stray = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] grant_log[$];
  logic [63:0] pop_log[$];
  logic [63:0] exp_q[$];
  int          first_grant = -1;
  int          first_valid = -1;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Responses are driven just after the edge, after the stimulus (#1).
  always begin
    @(posedge clk);
    #2;
    if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_gnt) begin
        grant_log.push_back(imem_addr);
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + lat);
        if (first_grant < 0) first_grant = cyc;
      end
      if (instr_valid && first_valid < 0) first_valid = cyc;
      if (instr_valid && instr_ready && !redirect) pop_log.push_back({instr_pc, instr});
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic score_pops(input string tag);
    check_eq({tag, "_popcnt"}, 64'(pop_log.size() >= exp_q.size()), 64'd1);
    foreach (exp_q[i]) begin
      if (i < pop_log.size()) check_eq($sformatf("%s_pop%0d", tag, i), pop_log[i], exp_q[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic gnt, input logic rdy, input string tag);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stray       = 1'b0;
    imem_gnt    = gnt;
    instr_ready = rdy;
    grant_log.delete(); pop_log.delete(); exp_q.delete();
    pend_addr.delete(); pend_due.delete();
    first_grant = -1; first_valid = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_rst_req"},   64'(imem_req),    64'd0);
    check_eq({tag, "_rst_valid"}, 64'(instr_valid), 64'd0);
    check_eq({tag, "_rst_addr"},  64'(imem_addr),   64'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq({tag, "_rst_misalign"}, 64'(misalign_err), 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && pop_log.size() < n; i++) @(negedge clk);
    check_eq({tag, "_wait"}, 64'(pop_log.size() >= n), 64'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;

    // T1: sequential fetch, 1-cycle memory, decoder always ready.
    lat = 1;
    apply_reset(1'b1, 1'b1, "t1");
    tick(12);
    check_eq("t1_g0", 64'(grant_log[0]), 64'h0);
    check_eq("t1_g1", 64'(grant_log[1]), 64'h4);
    check_eq("t1_g2", 64'(grant_log[2]), 64'h8);
    check_eq("t1_latency", 64'(first_valid - first_grant), 64'd2);
    exp_q.push_back({32'h0000_0000, 32'hC0DE_0000});
    exp_q.push_back({32'h0000_0004, 32'hC0DE_0004});
    exp_q.push_back({32'h0000_0008, 32'hC0DE_0008});
    score_pops("t1");

    // T2: decoder stalled, credit stops after two grants.
    lat = 1;
    apply_reset(1'b1, 1'b0, "t2");
    tick(10);
    @(negedge clk);
    check_eq("t2_grants",  64'(grant_log.size()), 64'd2);
    check_eq("t2_req_off", 64'(imem_req),         64'd0);
    check_eq("t2_head_pc", 64'(instr_pc),         64'h0);
    tick(1); instr_ready = 1'b1;
    tick(1); instr_ready = 1'b0;
    @(negedge clk);
    check_eq("t2_req_back", 64'(imem_req), 64'd1);
    exp_q.push_back({32'h0000_0000, 32'hC0DE_0000});
    score_pops("t2");
    tick(3);
    check_eq("t2_grant3", 64'(grant_log[2]), 64'h8);

    // T3: redirect with two requests outstanding (3-cycle memory).
    lat = 3;
    apply_reset(1'b1, 1'b1, "t3");
    tick(2);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    check_eq("t3_two_out", 64'(grant_log.size()), 64'd2);
    check_eq("t3_credit",  64'(imem_req),         64'd0);
    tick(1); redirect = 1'b0;
    @(negedge clk);
    check_eq("t3_flush_valid", 64'(instr_valid), 64'd0);
    check_eq("t3_flush_req",   64'(imem_req),    64'd0);
    @(negedge clk);
    check_eq("t3_flush_hold",  64'(imem_req),    64'd0);
    @(negedge clk);
    check_eq("t3_restart", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0000_0100});
    wait_pops(1, 20, "t3");
    exp_q.push_back({32'h0000_0100, 32'hC0DE_0100});
    score_pops("t3");

    // T4: redirect in the same cycle as a grant and a pop.
    lat = 1;
    apply_reset(1'b1, 1'b1, "t4");
    tick(6);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    pop_log.delete();
    @(negedge clk);
    check_eq("t4_setup", 64'({imem_req, imem_gnt, instr_valid}), 64'b111);
    tick(1); redirect = 1'b0;
    @(negedge clk);
    check_eq("t4_no_stale", 64'(instr_valid), 64'd0);
    check_eq("t4_flush_req", 64'(imem_req),   64'd0);
    wait_pops(1, 20, "t4");
    exp_q.push_back({32'h0000_0200, 32'hC0DE_0200});
    score_pops("t4");

    // T5: stray response ignored, address held without grant, pc wrap.
    lat = 1;
    apply_reset(1'b0, 1'b1, "t5");
    tick(1); stray = 1'b1;
    tick(1); stray = 1'b0;
    @(negedge clk);
    check_eq("t5_stray", 64'(instr_valid), 64'd0);
    check_eq("t5_hold",  {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    tick(1); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(1); redirect = 1'b0; imem_gnt = 1'b1;
    tick(8);
    check_eq("t5_g0", 64'(grant_log[0]), 64'hFFFF_FFFC);
    check_eq("t5_g1", 64'(grant_log[1]), 64'h0);
    exp_q.push_back({32'hFFFF_FFFC, 32'h3F21_FFFC});
    exp_q.push_back({32'h0000_0000, 32'hC0DE_0000});
    score_pops("t5");

    // T6: misaligned redirect target.
    lat = 1;
    apply_reset(1'b0, 1'b1, "t6");
    tick(1); redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick(1); redirect = 1'b0; imem_gnt = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    check_eq("t6_misalign_set", 64'(misalign_err), 64'd1);
`endif
    tick(6);
    check_eq("t6_g0", 64'(grant_log[0]), 64'h0000_0100);
    exp_q.push_back({32'h0000_0100, 32'hC0DE_0100});
    score_pops("t6");
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    check_eq("t6_misalign_sticky", 64'(misalign_err), 64'd1);
`endif
    apply_reset(1'b0, 1'b0, "t7");

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
